// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch and load/store requesters.
// Data has priority; a saturating starvation counter bounds how long a fetch can wait.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RESP_I,
        RESP_D_RD,
        RESP_D_WR
    } resp_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    resp_state_t state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        starve_hit;

    // Grant: data wins unless the fetch side has waited STARVE_MAX data grants.
    always_comb begin
        starve_hit = (starve_cnt_q == STARVE_LIM);
        inst_ack   = ~reset & inst_req & (~data_req | starve_hit);
        data_ack   = ~reset & data_req & ~(inst_req & starve_hit);
    end

    always_comb begin
        sram_en    = inst_ack | data_ack;
        sram_we    = data_ack & data_we;
        sram_addr  = '0;
        sram_wdata = '0;
        if (inst_ack) begin
            sram_addr = inst_addr;
        end else if (data_ack) begin
            sram_addr = data_addr;
        end
        if (sram_we) begin
            sram_wdata = data_wdata;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (inst_ack || !inst_req) begin
            starve_cnt_d = '0;
        end else if (data_ack && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        state_d = IDLE;
        if (inst_ack) begin
            state_d = RESP_I;
        end else if (data_ack) begin
            state_d = data_we ? RESP_D_WR : RESP_D_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Responses are gated by reset so an in-flight response vanishes immediately.
    always_comb begin
        inst_rvalid = ~reset & (state_q == RESP_I);
        data_rvalid = ~reset & ((state_q == RESP_D_RD) | (state_q == RESP_D_WR));
        inst_rdata  = '0;
        data_rdata  = '0;
        if (!reset && state_q == RESP_I) begin
            inst_rdata = sram_rdata;
        end
        if (!reset && state_q == RESP_D_RD) begin
            data_rdata = sram_rdata;
        end
    end

endmodule
